// File: rtl/euler_state_update.sv
// Explicit Euler state update x[i] <= x[i] + h*k[i] over an N-element vector.
// Ports: clk/rst, start + latched operands (step_in, n_in, x_base, k_base),
//   two sync read ports (mem_addr_x/mem_data_x, mem_addr_k/mem_data_k),
//   write-back on port x (mem_write, mem_wdata), status busy/done/overflow.
// Option: `define EULER_SATURATE_EN to saturate on overflow instead of wrap.
module euler_state_update #(
  parameter int WORD_SIZE     = 16,
  parameter int ADDRESS_WIDTH = 16,
  parameter int FRAC_BITS     = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WORD_SIZE-1:0]     step_in,
  input  logic [WORD_SIZE-1:0]     n_in,
  input  logic [ADDRESS_WIDTH-1:0] x_base,
  input  logic [ADDRESS_WIDTH-1:0] k_base,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_x,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_k,
  input  logic [WORD_SIZE-1:0]     mem_data_x,
  input  logic [WORD_SIZE-1:0]     mem_data_k,
  output logic                     mem_write,
  output logic [WORD_SIZE-1:0]     mem_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int PW = 2 * WORD_SIZE;
  localparam int HW = PW - WORD_SIZE + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CALC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [WORD_SIZE-1:0] r_h;
  logic [WORD_SIZE-1:0] r_n;
  logic [WORD_SIZE-1:0] r_i;

  logic signed [PW-1:0] w_p;
  logic signed [PW-1:0] w_q;
  logic signed [PW:0]   w_s;
  logic signed [PW:0]   w_x;
  logic [HW-1:0]        w_q_hi;
  logic [HW:0]          w_s_hi;
  logic                 w_q_ovf;
  logic                 w_s_ovf;
  logic                 w_ovf;
  logic [WORD_SIZE-1:0] w_wdata;
  logic                 w_last;

  // Full-precision product, then arithmetic shift back to the word format.
  assign w_p = $signed(r_h) * $signed(mem_data_k);
  assign w_q = w_p >>> FRAC_BITS;

  // One guard bit so the sum of x and an unbounded q is exact.
  assign w_x = $signed({{(PW + 1 - WORD_SIZE){mem_data_x[WORD_SIZE-1]}},
                        mem_data_x});
  assign w_s = $signed({w_q[PW-1], w_q}) + w_x;

  // A value fits in a signed word iff all bits above the word's sign
  // bit match that sign bit.
  assign w_q_hi  = w_q[PW-1:WORD_SIZE-1];
  assign w_s_hi  = w_s[PW:WORD_SIZE-1];
  assign w_q_ovf = (w_q_hi != '0) && (w_q_hi != '1);
  assign w_s_ovf = (w_s_hi != '0) && (w_s_hi != '1);
  assign w_ovf   = w_q_ovf | w_s_ovf;

`ifdef EULER_SATURATE_EN
  always_comb begin
    w_wdata = w_s[WORD_SIZE-1:0];
    if (w_ovf) begin
      if (w_s[PW]) begin
        w_wdata = {1'b1, {(WORD_SIZE - 1){1'b0}}};
      end else begin
        w_wdata = {1'b0, {(WORD_SIZE - 1){1'b1}}};
      end
    end
  end
`else
  assign w_wdata = w_s[WORD_SIZE-1:0];
`endif

  assign w_last = (r_i == r_n - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_h        <= '0;
      r_n        <= '0;
      r_i        <= '0;
      mem_addr_x <= '0;
      mem_addr_k <= '0;
      mem_write  <= 1'b0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_h        <= step_in;
            r_n        <= n_in;
            r_i        <= '0;
            mem_addr_x <= x_base;
            mem_addr_k <= k_base;
            overflow   <= 1'b0;
            busy       <= 1'b1;
            if (n_in != '0) begin
              r_state <= S_READ;
            end else begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_READ: begin
          r_state <= S_CALC;
        end
        S_CALC: begin
          mem_wdata <= w_wdata;
          mem_write <= 1'b1;
          overflow  <= overflow | w_ovf;
          r_state   <= S_WRITE;
        end
        S_WRITE: begin
          mem_write <= 1'b0;
          if (w_last) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            // Addresses advance with i; wrap-around is intended.
            r_i        <= r_i + 1'b1;
            mem_addr_x <= mem_addr_x + 1'b1;
            mem_addr_k <= mem_addr_k + 1'b1;
            r_state    <= S_READ;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_euler_state_update.sv
// Scoreboard bench for euler_state_update: model pushes expected writes,
// a monitor pops them as the DUT writes.
module tb_euler_state_update;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] step_in = '0;
  logic [15:0] n_in = '0;
  logic [15:0] x_base = '0;
  logic [15:0] k_base = '0;
  logic [15:0] mem_addr_x;
  logic [15:0] mem_addr_k;
  logic [15:0] mem_data_x;
  logic [15:0] mem_data_k;
  logic        mem_write;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        overflow;

  euler_state_update dut (
    .clk(clk), .rst(rst), .start(start),
    .step_in(step_in), .n_in(n_in),
    .x_base(x_base), .k_base(k_base),
    .mem_addr_x(mem_addr_x), .mem_addr_k(mem_addr_k),
    .mem_data_x(mem_data_x), .mem_data_k(mem_data_k),
    .mem_write(mem_write), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic        ld_en = 1'b0;
  logic [15:0] ld_a = '0;
  logic [15:0] ld_d = '0;

  always @(posedge clk) begin
    mem_data_x <= mem[mem_addr_x];
    mem_data_k <= mem[mem_addr_k];
    if (mem_write) mem[mem_addr_x] <= mem_wdata;
    if (ld_en) mem[ld_a] <= ld_d;
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk = 0;
  int  n_err = 0;
  int  n_wr = 0;
  int  n_busy = 0;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy) n_busy++;
    if (mem_write) begin
      wr_t e;
      n_wr++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr_x, e.a);
        chk("wr_data", mem_wdata, e.d);
      end
    end
  end

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    ref_mem[a] = d;
    ld_en = 1'b1;
    ld_a = a;
    ld_d = d;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic model(input int n, input logic [15:0] h,
                       input logic [15:0] xb, input logic [15:0] kb,
                       output bit ovf);
    ovf = 0;
    for (int i = 0; i < n; i++) begin
      logic [15:0] ax;
      logic [15:0] ak;
      logic [15:0] w;
      longint x, k, hh, q, s;
      bit o;
      ax = xb + 16'(i);
      ak = kb + 16'(i);
      x = longint'($signed(ref_mem[ax]));
      k = longint'($signed(ref_mem[ak]));
      hh = longint'($signed(h));
      q = (hh * k) >>> 7;
      s = x + q;
      o = (q > 32767) || (q < -32768) || (s > 32767) || (s < -32768);
`ifdef EULER_SATURATE_EN
      if (o) w = (s < 0) ? 16'h8000 : 16'h7FFF;
      else   w = 16'(s);
`else
      w = 16'(s);
`endif
      ovf |= o;
      ref_mem[ax] = w;
      exp_q.push_back('{ax, w});
    end
  endtask

  task automatic run(input int n, input logic [15:0] h,
                     input logic [15:0] xb, input logic [15:0] kb,
                     input bit mid);
    bit eo;
    int cyc, wr0, bz0;
    model(n, h, xb, kb, eo);
    @(posedge clk);
    #1;
    step_in = h;
    n_in = 16'(n);
    x_base = xb;
    k_base = kb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wr0 = n_wr;
    bz0 = n_busy;
    cyc = 1;
    chk("ovf_cleared", overflow, 0);
    while (!done && cyc < 3 * n + 20) begin
      if (mid && cyc == 2) begin
        start = 1'b1;
        step_in = ~h;
        n_in = 16'(n + 5);
        x_base = xb + 16'h0100;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    chk("done_cycle", cyc, 3 * n + 1);
    chk("overflow", overflow, eo);
    @(negedge clk);
    #1;
    chk("busy_cycles", n_busy - bz0, 3 * n + 1);
    chk("write_count", n_wr - wr0, n);
    chk("ovf_sticky", overflow, eo);
  endtask

  initial begin
    bit eo;
    int cyc;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr", mem_write, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_addr", {mem_addr_x, mem_addr_k, mem_wdata}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    load(16'h0000, 16'd128);
    load(16'h0100, 16'd128);
    run(1, 16'd64, 16'h0000, 16'h0100, 0);
    chk("single_val", mem[16'h0000], 192);

    for (int i = 0; i < 3; i++) load(16'h0010 + 16'(i), 16'h0000);
    load(16'h0020, 16'd128);
    load(16'h0021, 16'hFF80);
    load(16'h0022, 16'd256);
    run(3, 16'd128, 16'h0010, 16'h0020, 0);
    chk("n3_x0", mem[16'h0010], 16'd128);
    chk("n3_x1", mem[16'h0011], 16'hFF80);
    chk("n3_x2", mem[16'h0012], 16'd256);
    run(3, 16'd128, 16'h0010, 16'h0020, 0);
    chk("b2b_x1", mem[16'h0011], 16'hFF00);

    run(0, 16'd5, 16'h0300, 16'h0400, 0);

    load(16'h0040, 16'h7F00);
    load(16'h0050, 16'h7FFF);
    run(1, 16'h7FFF, 16'h0040, 16'h0050, 0);
`ifdef EULER_SATURATE_EN
    chk("ovf_val", mem[16'h0040], 16'h7FFF);
`else
    chk("ovf_val", mem[16'h0040], 16'h7D00);
`endif

    for (int i = 0; i < 4; i++) begin
      load(16'h0060 + 16'(i), 16'(100 * i));
      load(16'h0070 + 16'(i), 16'(50 + i));
    end
    run(4, 16'd300, 16'h0060, 16'h0070, 1);

    for (int i = 0; i < 4; i++) begin
      load(16'h0080 + 16'(i), 16'(7 * i));
      load(16'h0090 + 16'(i), 16'(1000 + i));
    end
    model(4, 16'd77, 16'h0080, 16'h0090, eo);
    @(posedge clk);
    #1;
    step_in = 16'd77;
    n_in = 16'd4;
    x_base = 16'h0080;
    k_base = 16'h0090;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 5) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_wr", mem_write, 0);
    chk("arst_outs", {mem_addr_x, mem_addr_k, mem_wdata}, 0);
    chk("arst_pending", exp_q.size(), 3);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      load(16'h0080 + 16'(i), 16'(7 * i));
      load(16'h0090 + 16'(i), 16'(1000 + i));
    end
    run(4, 16'd77, 16'h0080, 16'h0090, 0);

    for (int i = 0; i < 4; i++) begin
      load(16'hFFFE + 16'(i), 16'(i + 1));
      load(16'h7FFE + 16'(i), 16'(640 - i));
    end
    run(4, 16'd200, 16'hFFFE, 16'h7FFE, 0);

    for (int r = 0; r < 12; r++) begin
      int n;
      logic [15:0] h, xb, kb;
      n = (r == 5) ? 0 : int'($urandom_range(1, 8));
      h = (r % 2 == 0) ? 16'($urandom_range(0, 65535))
                       : 16'($urandom_range(0, 511)) - 16'd256;
      xb = 16'($urandom_range(0, 65535));
      kb = (r % 3 == 0) ? xb + 16'($urandom_range(0, 3))
                        : 16'($urandom_range(0, 65535));
      for (int i = 0; i < n; i++) begin
        load(xb + 16'(i), 16'($urandom_range(0, 65535)));
        load(kb + 16'(i), 16'($urandom_range(0, 65535)));
      end
      run(n, h, xb, kb, r == 7);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/euler_state_update.md
Name: euler_state_update

Overview:
- Downstream consumer of the step-size stage. Once that stage accepts a step (proceed), this block applies the explicit Euler state update to every element of the state vector.
- Update rule per element: x[i] <= x[i] + h*k[i], for i = 0..N-1.
- Reads x[i] and derivative k[i] from two synchronous memory read ports, then writes the result back over x[i].
- All arithmetic is signed fixed-point, same format as the step stage (7 fraction bits).

Parameters:
- WORD_SIZE, 16, data word width (signed two's complement).
- ADDRESS_WIDTH, 16, memory address width.
- FRAC_BITS, 7, number of fraction bits in the fixed-point format.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- step_in  in  WORD_SIZE  step h (the step stage's step_out); latched on start.
- n_in  in  WORD_SIZE  element count N, unsigned; latched on start.
- x_base  in  ADDRESS_WIDTH  base address of the x vector; latched on start.
- k_base  in  ADDRESS_WIDTH  base address of the k vector; latched on start.
- mem_addr_x  out  ADDRESS_WIDTH  read address, port 1; also used as the write address.
- mem_addr_k  out  ADDRESS_WIDTH  read address, port 2.
- mem_data_x  in  WORD_SIZE  port 1 read data, valid one cycle after its address.
- mem_data_k  in  WORD_SIZE  port 2 read data, valid one cycle after its address.
- mem_write  out  1  write enable for x[i] (data mem_wdata, address mem_addr_x).
- mem_wdata  out  WORD_SIZE  updated x[i].
- busy  out  1  high from the cycle after start is accepted until DONE is exited.
- done  out  1  one-cycle completion pulse.
- overflow  out  1  sticky; set on any arithmetic overflow; cleared on rst or on an accepted start.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - State goes to IDLE.
  - All outputs 0: busy, done, mem_write, overflow, mem_wdata, mem_addr_x, mem_addr_k.
  - Internal counters and latches cleared.
  - No partial write may occur after reset asserts.
- States: IDLE, READ, CALC, WRITE, DONE.
- IDLE:
  - start=1 latches h, N, x_base, k_base, clears overflow and sets index i=0.
  - Next state is READ if N != 0, otherwise DONE.
  - start=0 keeps the block in IDLE.
- start is ignored in every state other than IDLE.
- READ:
  - Drive mem_addr_x = x_base+i and mem_addr_k = k_base+i.
  - Next state CALC.
- CALC:
  - mem_data_x and mem_data_k are valid in this cycle.
  - Compute p = h * k[i] as a full 2*WORD_SIZE signed product.
  - q = p >>> FRAC_BITS (arithmetic shift, i.e. truncation toward minus infinity).
  - s = x[i] + q.
  - Register s; set overflow if q or s does not fit in WORD_SIZE signed bits.
  - Next state WRITE.
- WRITE:
  - mem_write=1, mem_wdata = registered s, mem_addr_x unchanged (x_base+i).
  - If i == N-1, next state is DONE; otherwise i <= i+1 and next state is READ.
- DONE: done=1 for exactly one cycle, busy=1, next state IDLE.
- Latency: done is high in cycle 3N+1 after the start sampling edge. N=0 gives done one cycle after start.
- Address arithmetic wraps modulo 2^ADDRESS_WIDTH, with no error.
- i counts as an unsigned WORD_SIZE value; N=2^WORD_SIZE-1 is legal.
- mem_write is high only in WRITE, and for exactly one cycle per element.
- Aliasing: when x and k regions overlap, each element is read in READ before it is written, so element i always uses the pre-update x[i].

Optional Feature:
- Macro: EULER_SATURATE_EN.
- Defined: on overflow, the written value saturates to the most positive (0x7FFF) or most negative (0x8000) WORD_SIZE value, following the sign of the exact sum. overflow is set.
- Undefined: the written value is the low WORD_SIZE bits of the exact sum (two's complement wrap). overflow is still set.

Test Plan:
- Single element: h=64 (0.5), k=128 (1.0), x=128 (1.0), N=1.
  - Expect mem_wdata=192 in cycle 3 after start, done in cycle 4, overflow=0.
- N=3 run with bases x_base=0x10, k_base=0x20, k={128,-128,256}, x={0,0,0}, h=128.
  - Expect writes 128, 0xFF80, 256 at 0x10, 0x11, 0x12.
  - Exactly 3 mem_write pulses; done at cycle 10.
- N=0: expect done one cycle after start, no mem_write, busy high for exactly 1 cycle.
- Overflow: x=0x7F00, k=0x7FFF, h=0x7FFF, N=1.
  - overflow=1.
  - Written value 0x7FFF with EULER_SATURATE_EN, wrapped low bits without it.
  - overflow stays set after done and clears on the next start.
- Reset during CALC of element 1 of N=4:
  - mem_write, busy and done drop to 0 immediately.
  - No further writes occur.
  - A new start then completes normally.
- start pulsed while busy is ignored. A back-to-back start in the cycle after done is accepted.
